// File: rtl/vga_pattern_defs.sv
// vga_pattern_defs: pattern mode encodings, default LFSR seeds and default
// resolution/geometry constants shared by the pattern generator.
package vga_pattern_defs;
  typedef enum logic [2:0] {
    MODE_BLACK   = 3'd0,
    MODE_NOISE   = 3'd1,
    MODE_STATIC  = 3'd2,
    MODE_BARS    = 3'd3,
    MODE_CHECKER = 3'd4,
    MODE_BOX     = 3'd5
  } mode_e;
  localparam int DEF_RES_H    = 1280;
  localparam int DEF_RES_V    = 720;
  localparam int DEF_MARGIN_X = 50;
  localparam int DEF_MARGIN_Y = 100;
  localparam int DEF_BOX_W    = 64;
  localparam int DEF_BOX_H    = 64;
  localparam int DEF_STEP     = 2;
  localparam logic [63:0] SEED_R = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] SEED_G = 64'hC2B2_AE3D_27D4_EB4F;
  localparam logic [63:0] SEED_B = 64'h1656_67B1_9E37_79F9;
endpackage

// File: rtl/lfsr_rng.sv
// lfsr_rng: 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1) yielding one random bit per clock.
module lfsr_rng #(
  parameter logic [63:0] SEED = 64'h1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic RND_BIT
);
  logic [63:0] lfsr_q, lfsr_d;
  // the zero state is unreachable from a nonzero seed; reloading keeps it that way regardless
  assign lfsr_d = lfsr_q == '0 ? SEED : {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign RND_BIT = lfsr_q[63];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern colour generator; all outputs registered one pixel clock after
// the coordinate/sync inputs, pattern selection latched on frame_start.
module vga_pattern_gen
  import vga_pattern_defs::*;
#(
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter int XW       = 13,
  parameter int RES_H    = DEF_RES_H,
  parameter int RES_V    = DEF_RES_V,
  parameter int MARGIN_X = DEF_MARGIN_X,
  parameter int MARGIN_Y = DEF_MARGIN_Y,
  parameter int BOX_W    = DEF_BOX_W,
  parameter int BOX_H    = DEF_BOX_H,
  parameter int STEP     = DEF_STEP
) (
  input  logic          PIXEL_CLK,
  input  logic          RST_N,
  input  logic [XW-1:0] locX,
  input  logic [XW-1:0] locY,
  input  logic          in_image,
  input  logic          sync_h,
  input  logic          sync_v,
  input  logic [2:0]    mode,
  input  logic          frame_start,
  output logic [RW-1:0] vgaRed,
  output logic [GW-1:0] vgaGreen,
  output logic [BW-1:0] vgaBlue,
  output logic          Hsync,
  output logic          Vsync,
  output logic [15:0]   frame_cnt
);
  localparam logic [XW:0] STEP_W  = (XW+1)'(STEP);
  localparam logic [XW:0] LIM_X   = (XW+1)'(RES_H - BOX_W);
  localparam logic [XW:0] LIM_Y   = (XW+1)'(RES_V - BOX_H);
  localparam logic [XW:0] BOX_W_W = (XW+1)'(BOX_W);
  localparam logic [XW:0] BOX_H_W = (XW+1)'(BOX_H);
  localparam logic [XW:0] SX0     = (XW+1)'(MARGIN_X);
  localparam logic [XW:0] SX1     = (XW+1)'(RES_H - MARGIN_X);
  localparam logic [XW:0] SY0     = (XW+1)'(MARGIN_Y);
  localparam logic [XW:0] SY1     = (XW+1)'(RES_V - MARGIN_Y);
  localparam logic [XW+3:0] RES_H_W = (XW+4)'(RES_H);

  logic [2:0]    mode_q;
  logic [XW-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [15:0]   cnt_q;
  logic [RW-1:0] red_q;
  logic [GW-1:0] green_q;
  logic [BW-1:0] blue_q;
  logic          hs_q, vs_q;
  logic          rnd_r, rnd_g, rnd_b;
  logic [XW:0]   x_w, y_w;
  logic [XW+3:0] bar_w;
  logic [2:0]    bar, noise, pat;
  logic          in_static, in_box;

  lfsr_rng #(.SEED(SEED_R)) u_lfsr_r (.clk_i(PIXEL_CLK), .rst_ni(RST_N), .RND_BIT(rnd_r));
  lfsr_rng #(.SEED(SEED_G)) u_lfsr_g (.clk_i(PIXEL_CLK), .rst_ni(RST_N), .RND_BIT(rnd_g));
  lfsr_rng #(.SEED(SEED_B)) u_lfsr_b (.clk_i(PIXEL_CLK), .rst_ni(RST_N), .RND_BIT(rnd_b));

  // returns {direction, position}; direction 1 means decreasing; reaching a limit clamps and reverses
  function automatic logic [XW:0] bounce(input logic [XW-1:0] pos, input logic dec, input logic [XW:0] lim);
    logic [XW:0] up;
    up = {1'b0, pos} + STEP_W;
    if (dec) return ({1'b0, pos} <= STEP_W) ? '0 : {1'b1, pos - STEP_W[XW-1:0]};
    return (up >= lim) ? {1'b1, lim[XW-1:0]} : {1'b0, up[XW-1:0]};
  endfunction

  assign {dir_x_d, box_x_d} = bounce(box_x_q, dir_x_q, LIM_X);
  assign {dir_y_d, box_y_d} = bounce(box_y_q, dir_y_q, LIM_Y);

  assign x_w       = {1'b0, locX};
  assign y_w       = {1'b0, locY};
  assign bar_w     = ({4'b0, locX} << 3) / RES_H_W;
  assign bar       = bar_w > (XW+4)'(7) ? 3'd7 : bar_w[2:0];
  assign noise     = {rnd_r, rnd_g, rnd_b};
  assign in_static = x_w >= SX0 && x_w < SX1 && y_w >= SY0 && y_w < SY1;
  assign in_box    = x_w >= {1'b0, box_x_q} && x_w < {1'b0, box_x_q} + BOX_W_W &&
                     y_w >= {1'b0, box_y_q} && y_w < {1'b0, box_y_q} + BOX_H_W;

  // pat holds one on/off bit per channel; modes 6 and 7 fall through to noise
  assign pat = !in_image                ? 3'b000 :
               mode_q == MODE_BLACK     ? 3'b000 :
               mode_q == MODE_STATIC    ? (in_static ? 3'b111 : noise) :
               mode_q == MODE_BARS      ? bar :
               mode_q == MODE_CHECKER   ? {3{locX[5] ^ locY[5]}} :
               mode_q == MODE_BOX       ? {3{in_box}} :
                                          noise;

  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_BLACK;
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else begin
      red_q   <= {RW{pat[2]}};
      green_q <= {GW{pat[1]}};
      blue_q  <= {BW{pat[0]}};
      hs_q    <= sync_h;
      vs_q    <= sync_v;
      if (frame_start) begin
        mode_q  <= mode;
        box_x_q <= box_x_d;
        box_y_q <= box_y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
        cnt_q   <= cnt_q + 16'd1;
      end
    end
  end

  assign vgaRed    = red_q;
  assign vgaGreen  = green_q;
  assign vgaBlue   = blue_q;
  assign Hsync     = hs_q;
  assign Vsync     = vs_q;
  assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized and directed stimulus against a behavioural model; a monitor
// pops one expected pixel per cycle and compares it with the registered outputs.
module tb_vga_pattern_gen;
  localparam int RES_H = 1280, RES_V = 720, MX = 50, MY = 100, BOXW = 64, BOXH = 64, STEP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] locX = '0, locY = '0;
  logic        in_image = 1'b0, sync_h = 1'b0, sync_v = 1'b0, frame_start = 1'b0;
  logic [2:0]  mode = '0;
  logic [2:0]  vgaRed, vgaGreen;
  logic [1:0]  vgaBlue;
  logic        Hsync, Vsync;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .PIXEL_CLK(clk), .RST_N(rst_n), .locX(locX), .locY(locY), .in_image(in_image),
    .sync_h(sync_h), .sync_v(sync_v), .mode(mode), .frame_start(frame_start),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .Hsync(Hsync), .Vsync(Vsync),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic        noise;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic        hs, vs;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0, passes = 0, noise_changes = 0;
  int am = 0, bx = 0, by = 0, dx = 1, dy = 1, fc = 0;
  logic [7:0] last_noise = '0;

  function automatic void axis(inout int p, inout int d, input int lim);
    int nxt;
    nxt = p + d * STEP;
    if (nxt >= lim) begin p = lim; d = -1; end
    else if (nxt <= 0) begin p = 0; d = 1; end
    else p = nxt;
  endfunction

  function automatic exp_t white(input exp_t e);
    exp_t o;
    o = e; o.r = 3'd7; o.g = 3'd7; o.b = 2'd3;
    return o;
  endfunction

  function automatic exp_t colour(input int x, input int y, input bit img);
    exp_t e;
    int m, bar;
    e = '0;
    m = am >= 6 ? 1 : am;
    if (!img || m == 0) return e;
    case (m)
      2: begin
        if (x >= MX && x < RES_H - MX && y >= MY && y < RES_V - MY) e = white(e);
        else e.noise = 1'b1;
      end
      3: begin
        bar = x * 8 / RES_H;
        e.r = (bar & 4) != 0 ? 3'd7 : 3'd0;
        e.g = (bar & 2) != 0 ? 3'd7 : 3'd0;
        e.b = (bar & 1) != 0 ? 2'd3 : 2'd0;
      end
      4: if (((x / 32) + (y / 32)) % 2 == 1) e = white(e);
      5: if (x >= bx && x < bx + BOXW && y >= by && y < by + BOXH) e = white(e);
      default: e.noise = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive(input int x, input int y, input bit img, input bit sh, input bit sv,
                       input int md, input bit fs);
    exp_t e;
    @(negedge clk);
    locX = 13'(x); locY = 13'(y); in_image = img; sync_h = sh; sync_v = sv;
    mode = 3'(md); frame_start = fs;
    e = colour(x, y, img);
    e.hs = sh; e.vs = sv;
    if (fs) begin
      am = md;
      axis(bx, dx, RES_H - BOXW);
      axis(by, dy, RES_V - BOXH);
      fc = (fc + 1) % 65536;
    end
    e.fc = 16'(fc);
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; frame_start = 1'b0; in_image = 1'b0;
    #1;
    check("rst_red", vgaRed, 0);
    check("rst_green", vgaGreen, 0);
    check("rst_blue", vgaBlue, 0);
    check("rst_hsync", Hsync, 0);
    check("rst_vsync", Vsync, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    am = 0; bx = 0; by = 0; dx = 1; dy = 1; fc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
      q.delete();
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    logic ok;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      ok = e.noise ? ((vgaRed == 3'd0 || vgaRed == 3'd7) && (vgaGreen == 3'd0 || vgaGreen == 3'd7) &&
                      (vgaBlue == 2'd0 || vgaBlue == 2'd3))
                   : (vgaRed == e.r && vgaGreen == e.g && vgaBlue == e.b);
      if (e.noise && {vgaRed, vgaGreen, vgaBlue} != last_noise) noise_changes++;
      if (e.noise) last_noise = {vgaRed, vgaGreen, vgaBlue};
      checks++;
      if (ok && Hsync == e.hs && Vsync == e.vs && frame_cnt == e.fc) passes++;
      else $display("FAIL pixel %0d: got rgb=%0d,%0d,%0d hs=%0b vs=%0b fc=%0d, want noise=%0b rgb=%0d,%0d,%0d hs=%0b vs=%0b fc=%0d",
                    checks, vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_cnt,
                    e.noise, e.r, e.g, e.b, e.hs, e.vs, e.fc);
    end
  end

  initial begin
    int x, y, md;
    bit img, fs;
    repeat (2) @(negedge clk);
    check("init_red", vgaRed, 0);
    check("init_hsync", Hsync, 0);
    check("init_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    // mode latch: a mid-frame request must wait for frame_start; the pulse pixel keeps the old mode
    drive(0, 0, 1, 0, 1, 0, 1);
    drive(1279, 10, 1, 0, 0, 3, 0);
    drive(640, 10, 1, 0, 0, 3, 0);
    drive(1279, 10, 1, 0, 0, 3, 1);
    drive(0, 10, 1, 0, 0, 3, 0);
    drive(1279, 10, 1, 0, 0, 3, 0);
    drive(640, 10, 1, 0, 0, 3, 0);
    drive(479, 10, 1, 0, 0, 3, 0);
    // blanking and sync latency in checkerboard mode
    drive(0, 0, 0, 0, 0, 4, 1);
    drive(100, 5, 0, 1, 0, 4, 0);
    drive(100, 5, 1, 0, 1, 4, 0);
    drive(96, 31, 1, 0, 0, 4, 0);
    drive(95, 32, 1, 0, 0, 4, 0);
    // asynchronous reset mid-line while showing bars
    drive(0, 0, 1, 0, 0, 3, 1);
    drive(1279, 20, 1, 1, 1, 3, 0);
    do_reset();
    // static box with noise margin
    drive(0, 0, 0, 0, 0, 2, 1);
    drive(640, 360, 1, 0, 0, 2, 0);
    drive(50, 100, 1, 0, 0, 2, 0);
    drive(1229, 619, 1, 0, 0, 2, 0);
    noise_changes = 0;
    for (int i = 0; i < 64; i++) drive(10, 10, 1, 0, 0, 2, 0);
    drain();
    check("noise_toggles", noise_changes > 0, 1);
    // moving box: walk to box_x=1214 and watch the bounce at the right edge
    do_reset();
    for (int i = 0; i < 607; i++) drive(0, 0, 0, 0, 0, 5, 1);
    check("model_box_x", bx, 1214);
    drive(1213, by + 1, 1, 0, 0, 5, 0);
    drive(1214, by + 1, 1, 0, 0, 5, 0);
    drive(1277, by + 1, 1, 0, 0, 5, 0);
    drive(1278, by + 1, 1, 0, 0, 5, 0);
    drive(0, 0, 0, 0, 0, 5, 1);
    drive(1215, by + 1, 1, 0, 0, 5, 0);
    drive(1216, by + 1, 1, 0, 0, 5, 0);
    drive(1279, by + 1, 1, 0, 0, 5, 0);
    drive(0, 0, 0, 0, 0, 5, 1);
    drive(1213, by, 1, 0, 0, 5, 0);
    drive(1214, by + 63, 1, 0, 0, 5, 0);
    drive(1214, by + 64, 1, 0, 0, 5, 0);
    // randomized traffic across all modes
    for (int i = 0; i < 3000; i++) begin
      img = ($urandom % 4) != 0;
      x = img ? int'($urandom % RES_H) : int'($urandom % 1400);
      y = img ? int'($urandom % RES_V) : int'($urandom % 800);
      md = int'($urandom % 8);
      fs = ($urandom % 4) == 0;
      drive(x, y, img, 1'($urandom), 1'($urandom), md, fs);
    end
    // frame counter wrap
    do_reset();
    for (int i = 0; i < 65536; i++) drive(0, 0, 0, 0, 0, int'($urandom % 8), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drain();
    check("frame_cnt_wrap", frame_cnt, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
